// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared definitions for the M-extension scheduler: 3-bit M op
//               encodings, divider FSM state type and issue-queue entry type.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

  // Queue entries carry tags at this fixed width. Narrower ROB tags are
  // zero-extended on enqueue and truncated on issue.
  localparam int MDU_TAG_W_MAX = 16;

  // M op encodings. Bit 2 selects the divider class; bits [1:0] are the
  // functional-unit sub-op.
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_BUSY = 2'd1,
    D_WB   = 2'd2
  } div_state_e;

  typedef struct packed {
    logic [2:0]               uop;
    logic [MDU_TAG_W_MAX-1:0] tag;
  } mdu_entry_t;

  function automatic logic is_div_class(input logic [2:0] uop);
    return uop[2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_sched_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mdu_sched_fifo
// Description : Circular issue queue with dual enqueue and single dequeue.
//               enq0 is older than enq1; a lone enq1 takes the next slot.
// Ports       : clk, rst_n (async active-low), flush (sync clear),
//               enq0_valid/enq0_data, enq1_valid/enq1_data,
//               deq (pop head), head (entry at read pointer),
//               count (occupancy 0..DEPTH).
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_sched_fifo
  import mdu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   enq0_valid,
  input  mdu_entry_t             enq0_data,
  input  logic                   enq1_valid,
  input  mdu_entry_t             enq1_data,
  input  logic                   deq,
  output mdu_entry_t             head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  mdu_entry_t      mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   wr_ptr_p1;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   n_enq;

  assign wr_ptr_p1 = wr_ptr + 1'b1;
  assign n_enq     = CW'(enq0_valid) + CW'(enq1_valid);
  assign head      = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + n_enq[PW-1:0];
      rd_ptr <= rd_ptr + PW'(deq);
      count  <= count + n_enq - CW'(deq);
    end
  end

  // Storage needs no reset: entries are only read while count says valid.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (enq0_valid) begin
        mem[wr_ptr] <= enq0_data;
        if (enq1_valid) begin
          mem[wr_ptr_p1] <= enq1_data;
        end
      end else if (enq1_valid) begin
        mem[wr_ptr] <= enq1_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mdu_sched.sv
`default_nettype none
// ============================================================================
// Module      : mdu_sched
// Description : Two-lane M-extension scheduler. Queues decoded ops in order,
//               issues one per cycle from the head to a pipelined multiplier
//               or an iterative divider, tracks multiplier latency in a
//               valid/tag shift register and arbitrates a single writeback
//               port (multiplier first).
// Config      : MDU_SCHED_BYPASS_EN - when defined, a lane0 op arriving at an
//               empty queue may issue in its accept cycle.
// Ports       : cpu_clock_i, cpu_reset_ni (async active-low), flush_i
//               lane{0,1}_valid_i/_uop_i/_tag_i  decoded op inputs
//               ready_o                          two entries free
//               mul_start_o/mul_op_o/mul_tag_o   multiplier issue
//               div_start_o/div_op_o/div_tag_o   divider issue
//               div_done_i, div_kill_o           divider handshake
//               wb_valid_o/wb_sel_o/wb_tag_o     writeback (sel 1 = divider)
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_sched
  import mdu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 6,
  parameter int MUL_LAT = 3
) (
  input  logic             cpu_clock_i,
  input  logic             cpu_reset_ni,
  input  logic             flush_i,
  input  logic             lane0_valid_i,
  input  logic [2:0]       lane0_uop_i,
  input  logic [TAG_W-1:0] lane0_tag_i,
  input  logic             lane1_valid_i,
  input  logic [2:0]       lane1_uop_i,
  input  logic [TAG_W-1:0] lane1_tag_i,
  output logic             ready_o,
  output logic             mul_start_o,
  output logic [1:0]       mul_op_o,
  output logic [TAG_W-1:0] mul_tag_o,
  output logic             div_start_o,
  output logic [1:0]       div_op_o,
  output logic [TAG_W-1:0] div_tag_o,
  input  logic             div_done_i,
  output logic             div_kill_o,
  output logic             wb_valid_o,
  output logic             wb_sel_o,
  output logic [TAG_W-1:0] wb_tag_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  div_state_e               state;
  div_state_e               state_nxt;
  logic [TAG_W-1:0]         div_tag_q;

  mdu_entry_t               head;
  mdu_entry_t               enq0_data;
  mdu_entry_t               enq1_data;
  logic [CW-1:0]            count;
  logic                     enq0_valid;
  logic                     enq1_valid;
  logic                     head_valid;
  logic                     head_issue;
  logic [TAG_W-1:0]         head_tag;
  logic                     accept;
  logic                     bypass;
  logic                     issue;
  logic [2:0]               issue_uop;
  logic [TAG_W-1:0]         issue_tag;

  logic [MUL_LAT-1:0]       mul_v;
  logic [MUL_LAT*TAG_W-1:0] mul_t;
  logic                     mul_done;
  logic [TAG_W-1:0]         mul_done_tag;
  logic                     div_wb;
  logic                     unused_head_tag;

  // ------------------------------------------------------------------------
  // Accept and issue
  // ------------------------------------------------------------------------
  assign ready_o    = (count <= CW'(DEPTH - 2));
  assign accept     = ready_o & ~flush_i;
  assign head_valid = (count != '0);
  assign head_tag   = head.tag[TAG_W-1:0];
  // Upper tag bits are zero by construction when TAG_W < MDU_TAG_W_MAX.
  assign unused_head_tag = ^head.tag;

  // A divide at the head waits for an idle divider; everything younger
  // waits behind it to keep issue in program order.
  assign head_issue = head_valid & ~flush_i &
                      (~is_div_class(head.uop) | (state == D_IDLE));

`ifdef MDU_SCHED_BYPASS_EN
  assign bypass = accept & lane0_valid_i & ~head_valid &
                  (~is_div_class(lane0_uop_i) | (state == D_IDLE));
`else
  assign bypass = 1'b0;
`endif

  assign issue     = head_issue | bypass;
  assign issue_uop = head_valid ? head.uop : lane0_uop_i;
  assign issue_tag = head_valid ? head_tag : lane0_tag_i;

  assign enq0_valid = accept & lane0_valid_i & ~bypass;
  assign enq1_valid = accept & lane1_valid_i;
  assign enq0_data  = '{uop: lane0_uop_i, tag: MDU_TAG_W_MAX'(lane0_tag_i)};
  assign enq1_data  = '{uop: lane1_uop_i, tag: MDU_TAG_W_MAX'(lane1_tag_i)};

  assign mul_start_o = issue & ~issue_uop[2];
  assign mul_op_o    = mul_start_o ? issue_uop[1:0] : 2'b00;
  assign mul_tag_o   = mul_start_o ? issue_tag : '0;
  assign div_start_o = issue & issue_uop[2];
  assign div_op_o    = div_start_o ? issue_uop[1:0] : 2'b00;
  assign div_tag_o   = div_start_o ? issue_tag : '0;

  mdu_sched_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (cpu_clock_i),
    .rst_n      (cpu_reset_ni),
    .flush      (flush_i),
    .enq0_valid (enq0_valid),
    .enq0_data  (enq0_data),
    .enq1_valid (enq1_valid),
    .enq1_data  (enq1_data),
    .deq        (head_issue),
    .head       (head),
    .count      (count)
  );

  // ------------------------------------------------------------------------
  // Multiplier latency tracking. Stage 0 captures the issue; the last stage
  // is the completion seen MUL_LAT cycles after mul_start_o.
  // ------------------------------------------------------------------------
  generate
    if (MUL_LAT == 1) begin : g_mul_lat1
      always_ff @(posedge cpu_clock_i or negedge cpu_reset_ni) begin
        if (!cpu_reset_ni) begin
          mul_v <= '0;
          mul_t <= '0;
        end else if (flush_i) begin
          mul_v <= '0;
          mul_t <= '0;
        end else begin
          mul_v <= mul_start_o;
          mul_t <= mul_tag_o;
        end
      end
    end else begin : g_mul_latn
      always_ff @(posedge cpu_clock_i or negedge cpu_reset_ni) begin
        if (!cpu_reset_ni) begin
          mul_v <= '0;
          mul_t <= '0;
        end else if (flush_i) begin
          mul_v <= '0;
          mul_t <= '0;
        end else begin
          mul_v <= {mul_v[MUL_LAT-2:0], mul_start_o};
          mul_t <= {mul_t[(MUL_LAT-1)*TAG_W-1:0], mul_tag_o};
        end
      end
    end
  endgenerate

  assign mul_done     = mul_v[MUL_LAT-1] & ~flush_i;
  assign mul_done_tag = mul_t[MUL_LAT*TAG_W-1 -: TAG_W];

  // ------------------------------------------------------------------------
  // Divider FSM
  // ------------------------------------------------------------------------
  always_ff @(posedge cpu_clock_i or negedge cpu_reset_ni) begin
    if (!cpu_reset_ni) begin
      state     <= D_IDLE;
      div_tag_q <= '0;
    end else begin
      state <= state_nxt;
      if (div_start_o) begin
        div_tag_q <= issue_tag;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    div_wb     = 1'b0;
    div_kill_o = 1'b0;
    if (flush_i) begin
      // A done pulse in the flush cycle is dropped along with the division.
      state_nxt  = D_IDLE;
      div_kill_o = (state == D_BUSY);
    end else begin
      case (state)
        D_IDLE: if (div_start_o) state_nxt = D_BUSY;
        D_BUSY: if (div_done_i)  state_nxt = D_WB;
        D_WB: begin
          // Multiplier completions cannot be delayed, so they win the port.
          if (!mul_done) begin
            div_wb    = 1'b1;
            state_nxt = D_IDLE;
          end
        end
        default: state_nxt = D_IDLE;
      endcase
    end
  end

  assign wb_valid_o = mul_done | div_wb;
  assign wb_sel_o   = div_wb;
  assign wb_tag_o   = mul_done ? mul_done_tag : (div_wb ? div_tag_q : '0);

endmodule
`default_nettype wire
